alu_issue_queue: RTL

//   Command stage in front of the 4-bit combinational ALU. Buffers {a,b,opcode}

---
 rtl/alu_issue_queue.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Purpose  : Command FIFO in front of a combinational ALU. The FIFO head
//            drives the ALU inputs, and the ALU result is captured into a
//            one-entry valid/ready output stage.
// Options  : ALU_FLAGS_EN - adds out_zero_o, a registered zero flag that is
//            captured and held together with out_result_o.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_a_i,
  input  logic [DATA_W-1:0]      in_b_i,
  input  logic [OP_W-1:0]        in_op_i,
  output logic [DATA_W-1:0]      alu_a_o,
  output logic [DATA_W-1:0]      alu_b_o,
  output logic [OP_W-1:0]        alu_opcode_o,
  input  logic [DATA_W-1:0]      alu_result_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_result_o,
  output logic [OP_W-1:0]        out_op_o,
`ifdef ALU_FLAGS_EN
  output logic                   out_zero_o,
`endif
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // FIFO storage; contents are don't-care until written, so no reset
  logic [DATA_W-1:0] mem_a_q  [DEPTH];
  logic [DATA_W-1:0] mem_b_q  [DEPTH];
  logic [OP_W-1:0]   mem_op_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [OP_W-1:0]   op_q, op_d;
`ifdef ALU_FLAGS_EN
  logic              zero_q, zero_d;
`endif

  logic push_w;
  logic load_w;
  logic not_empty_w;

  // Full check uses the registered count only, so a same-cycle pop never
  // lets a push through when the FIFO is full.
  assign in_ready_o  = (count_q != C_FULL);
  assign not_empty_w = (count_q != '0);
  assign push_w      = in_valid_i && in_ready_o;
  assign load_w      = not_empty_w && ((state_q == ST_EMPTY) || out_ready_i);

  // Head of FIFO drives the ALU; zeros when nothing is queued
  assign alu_a_o      = not_empty_w ? mem_a_q[rd_ptr_q]  : '0;
  assign alu_b_o      = not_empty_w ? mem_b_q[rd_ptr_q]  : '0;
  assign alu_opcode_o = not_empty_w ? mem_op_q[rd_ptr_q] : '0;

  assign out_valid_o  = (state_q == ST_FULL);
  assign out_result_o = res_q;
  assign out_op_o     = op_q;
  assign count_o      = count_q;
`ifdef ALU_FLAGS_EN
  assign out_zero_o   = zero_q;
`endif

  // Pointer and occupancy next-state: pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (load_w) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_w, load_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output stage next-state: capture on load, drain on accept, else hold
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    op_d    = op_q;
`ifdef ALU_FLAGS_EN
    zero_d  = zero_q;
`endif
    if (load_w) begin
      state_d = ST_FULL;
      res_d   = alu_result_i;
      op_d    = mem_op_q[rd_ptr_q];
`ifdef ALU_FLAGS_EN
      zero_d  = (alu_result_i == '0);
`endif
    end else if (out_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  // FIFO write port
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_a_q[wr_ptr_q]  <= in_a_i;
      mem_b_q[wr_ptr_q]  <= in_b_i;
      mem_op_q[wr_ptr_q] <= in_op_i;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_EMPTY;
      res_q    <= '0;
      op_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      res_q    <= res_d;
      op_q     <= op_d;
    end
  end

`ifdef ALU_FLAGS_EN
  // Zero flag register, held alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end
`endif

endmodule
`default_nettype wire
